fifo_wr_arbiter: RTL

Round-robin write-port arbiter that shares the write side of the team's async FIFO among N requesters in the write clock domain. Each requester offers a stream of beats with a last marker. The arbiter locks one requester per burst and drives the FIFO's `w_en`/`data_in`. It honours the FIFO's `full` flag as backpressure and enforces a maximum burst length so that no requester can starve the others.

---
 rtl/fifo_arb_pkg.sv | 26 ++
 rtl/rr_pick.sv | 42 ++++
 rtl/fifo_wr_arbiter.sv | 103 ++++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_arb_pkg
// Purpose  : Shared types and width helpers for the FIFO write-port arbiter.
// Revision : 1.0  initial release
// ============================================================================
package fifo_arb_pkg;

    // Arbiter FSM: waiting for a request, or locked onto one requester.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    // Width of a requester index (never narrower than one bit).
    function automatic int owner_width(input int n_req);
        return (n_req < 2) ? 1 : $clog2(n_req);
    endfunction

    // Width of a counter that must be able to hold MAX_BURST itself.
    function automatic int count_width(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational round-robin selector. Returns the first set request
//            at or above rr_ptr, wrapping modulo N_REQ.
// Revision : 1.0  initial release
// ============================================================================
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic             found,
    output logic [PTR_W-1:0] index
);

    // Two copies of the request vector: the upper copy stands in for the
    // wrapped-around requesters below the pointer.
    logic [2*N_REQ-1:0] w_dbl;
    logic [2*N_REQ-1:0] w_masked;

    assign w_dbl = {req, req};

    for (genvar g = 0; g < 2*N_REQ; g++) begin : g_mask
        assign w_masked[g] = w_dbl[g] & (g >= int'(rr_ptr));
    end

    // Lowest surviving bit wins; scanning downward leaves the lowest one last.
    always_comb begin
        found = 1'b0;
        index = '0;
        for (int i = 2*N_REQ - 1; i >= 0; i--) begin
            if (w_masked[i]) begin
                found = 1'b1;
                index = (i >= N_REQ) ? PTR_W'(i - N_REQ) : PTR_W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_arbiter
// Purpose  : Round-robin arbiter sharing the async FIFO write port among
//            N_REQ requesters, with full backpressure and a burst cap.
// Revision : 1.0  initial release
// ============================================================================
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [N_REQ-1:0]                req,
    input  logic [N_REQ*DATA_WIDTH-1:0]     req_data,
    input  logic [N_REQ-1:0]                req_last,
    output logic [N_REQ-1:0]                gnt,
    input  logic                            full,
    output logic                            w_en,
    output logic [DATA_WIDTH-1:0]           data_in,
    output logic                            busy,
    output logic [owner_width(N_REQ)-1:0]   owner
);

    localparam int c_ptr_w = owner_width(N_REQ);
    localparam int c_cnt_w = count_width(MAX_BURST);

    arb_state_t          r_state;
    logic [c_ptr_w-1:0]  r_owner;
    logic [c_ptr_w-1:0]  r_rr_ptr;
    logic [c_cnt_w-1:0]  r_beat_cnt;

    logic                w_found;
    logic [c_ptr_w-1:0]  w_pick;
    logic                w_xfer;
    logic                w_release;
    logic [c_cnt_w-1:0]  w_cnt_next;
    logic [c_ptr_w-1:0]  w_ptr_next;

    rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (c_ptr_w)
    ) u_rr_pick (
        .req    (req),
        .rr_ptr (r_rr_ptr),
        .found  (w_found),
        .index  (w_pick)
    );

    // A beat moves only when locked, the owner offers one and the FIFO has room.
    assign w_xfer     = (r_state == LOCK) & req[r_owner] & ~full;
    assign w_cnt_next = r_beat_cnt + c_cnt_w'(1);
    assign w_release  = w_xfer & (req_last[r_owner] | (w_cnt_next == c_cnt_w'(MAX_BURST)));
    assign w_ptr_next = (r_owner == c_ptr_w'(N_REQ - 1)) ? '0 : r_owner + c_ptr_w'(1);

    // Ready goes to the owner only, and only while the FIFO can accept.
    always_comb begin
        gnt = '0;
        if ((r_state == LOCK) && !full) begin
            gnt[r_owner] = 1'b1;
        end
    end

    assign w_en    = w_xfer;
    assign data_in = req_data[r_owner*DATA_WIDTH +: DATA_WIDTH];
    assign busy    = (r_state == LOCK);
    assign owner   = r_owner;

    // Lock/release FSM with the burst counter and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_owner    <= '0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_owner    <= w_pick;
                        r_state    <= LOCK;
                        r_beat_cnt <= '0;
                    end
                end
                LOCK: begin
                    if (w_xfer) begin
                        r_beat_cnt <= w_cnt_next;
                        if (w_release) begin
                            r_state  <= IDLE;
                            r_rr_ptr <= w_ptr_next;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
